// File: rtl/mask_sched_pkg.sv
// mask_sched_pkg
//   Shared definitions for the column-mask request scheduler: FSM state
//   encoding, the widest legal column count, id/column field widths and a
//   helper that decides whether a latched job must be rejected.
package mask_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int MAX_COLUMNS = 11;
   localparam int ID_W        = 3;
   localparam int COLS_W      = 16;

   // A job with no rows, no columns or more columns than the generator
   // supports never reaches the datapath.
   function automatic logic job_invalid(input logic [COLS_W-1:0] cols,
                                        input logic              row_cnt_zero);
      return row_cnt_zero || (cols == '0) || (cols > COLS_W'(MAX_COLUMNS));
   endfunction

endpackage

// File: rtl/mask_sched_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at the
//   requester after ptr and wraps modulo NUM_REQ; the first asserted request
//   wins.
//   Ports:
//     req   in  NUM_REQ  request vector
//     ptr   in  ID_W     index of the most recently served requester
//     grant out NUM_REQ  one-hot grant (all zero when no request)
//     idx   out ID_W     encoded index of the granted requester
//     any   out 1        at least one request present
module rr_arbiter
   import mask_sched_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      // off runs 1..NUM_REQ so the last-served requester is considered last.
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = int'(ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i == cand)) begin
               grant[i] = 1'b1;
               idx      = ID_W'(i);
               any      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mask_sched.sv
// mask_sched
//   Round-robin job scheduler in front of the column-mask address generator.
//   Accepts one job at a time from NUM_REQ requesters, latches its geometry,
//   gives the datapath a fresh rising enable, counts beats and reports
//   completion (id, beat count, error flag).
//   Optional feature: define MASK_SCHED_TIMEOUT_EN to add a watchdog that
//   aborts a job stuck in START, or stalled in RUN, for TIMEOUT_CYCLES cycles.
//   Ports:
//     i_clk, i_rst_n                  clock, synchronous active-low reset
//     i_req_valid / o_req_ready       per-requester request / one-hot accept
//     i_req_row_size/row_cnt/frame_off/cols   packed per-requester job fields
//     o_dp_en, o_dp_*                 datapath enable and latched geometry
//     i_dp_active, i_mem_ready        datapath activity, downstream ready
//     o_dp_ready                      ready forwarded to the datapath
//     o_done_valid/i_done_ready       completion handshake
//     o_done_id/beats/err             completion payload
//     o_busy                          scheduler not idle
module mask_sched
   import mask_sched_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_row_size,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_row_cnt,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_frame_off,
   input  logic [NUM_REQ*COLS_W-1:0] i_req_cols,
   output logic                      o_dp_en,
   output logic [ADDR_W-1:0]         o_dp_row_size,
   output logic [ADDR_W-1:0]         o_dp_row_cnt,
   output logic [ADDR_W-1:0]         o_dp_frame_off,
   output logic [COLS_W-1:0]         o_dp_cols,
   input  logic                      i_dp_active,
   input  logic                      i_mem_ready,
   output logic                      o_dp_ready,
   output logic                      o_done_valid,
   input  logic                      i_done_ready,
   output logic [ID_W-1:0]           o_done_id,
   output logic [ADDR_W-1:0]         o_done_beats,
   output logic                      o_done_err,
   output logic                      o_busy
);

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     rr_ptr_reg;
   logic [ID_W-1:0]     id_reg;
   logic [ADDR_W-1:0]   row_size_reg, row_cnt_reg, frame_off_reg, beats_reg;
   logic [COLS_W-1:0]   cols_reg;
   logic                err_reg;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [ID_W-1:0]     arb_idx;
   logic                arb_any;
   logic                beat;
   logic                reject;
   logic                wd_expired;

   // Unpack the flat request buses so the winner can be muxed by grant bit.
   logic [ADDR_W-1:0]   row_size_arr  [NUM_REQ];
   logic [ADDR_W-1:0]   row_cnt_arr   [NUM_REQ];
   logic [ADDR_W-1:0]   frame_off_arr [NUM_REQ];
   logic [COLS_W-1:0]   cols_arr      [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign row_size_arr[gi]  = i_req_row_size[gi*ADDR_W +: ADDR_W];
         assign row_cnt_arr[gi]   = i_req_row_cnt[gi*ADDR_W +: ADDR_W];
         assign frame_off_arr[gi] = i_req_frame_off[gi*ADDR_W +: ADDR_W];
         assign cols_arr[gi]      = i_req_cols[gi*COLS_W +: COLS_W];
      end
   endgenerate

   logic [ADDR_W-1:0]   sel_row_size, sel_row_cnt, sel_frame_off;
   logic [COLS_W-1:0]   sel_cols;

   always_comb begin
      sel_row_size  = '0;
      sel_row_cnt   = '0;
      sel_frame_off = '0;
      sel_cols      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_row_size  = row_size_arr[i];
            sel_row_cnt   = row_cnt_arr[i];
            sel_frame_off = frame_off_arr[i];
            sel_cols      = cols_arr[i];
         end
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req   (i_req_valid),
      .ptr   (rr_ptr_reg),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign reject = job_invalid(cols_reg, (row_cnt_reg == '0));
   assign beat   = i_dp_active & o_dp_ready;

`ifdef MASK_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_reg;
   logic            wd_count;

   // START counts every cycle; RUN counts only cycles where memory could
   // take a beat but the datapath offered none.
   assign wd_count   = (state_reg == ST_START) ||
                       ((state_reg == ST_RUN) && i_mem_ready && !beat);
   assign wd_expired = wd_count && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wd_reg <= '0;
      end else if (state_reg == ST_LOAD) begin
         wd_reg <= '0;
      end else if (beat && (state_reg == ST_RUN)) begin
         wd_reg <= '0;
      end else if (wd_count && !wd_expired) begin
         wd_reg <= wd_reg + WD_W'(1);
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (arb_any) state_next = ST_LOAD;
         ST_LOAD:  state_next = reject ? ST_DONE : ST_START;
         ST_START: begin
            if (wd_expired)       state_next = ST_DONE;
            else if (i_dp_active) state_next = ST_RUN;
         end
         ST_RUN:   if (wd_expired || !i_dp_active) state_next = ST_DONE;
         ST_DONE:  if (i_done_ready) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs. LOAD keeps the enable low so the generator always sees a
   // fresh rising edge at START.
   always_comb begin
      o_req_ready  = (state_reg == ST_IDLE) ? arb_grant : '0;
      o_dp_en      = (state_reg == ST_START) || (state_reg == ST_RUN);
      o_dp_ready   = o_dp_en & i_mem_ready;
      o_done_valid = (state_reg == ST_DONE);
      o_busy       = (state_reg != ST_IDLE);
   end

   // Job datapath registers: latched on accept, stable until the next accept.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
         id_reg        <= '0;
         row_size_reg  <= '0;
         row_cnt_reg   <= '0;
         frame_off_reg <= '0;
         cols_reg      <= '0;
         beats_reg     <= '0;
         err_reg       <= 1'b0;
      end else begin
         if ((state_reg == ST_IDLE) && arb_any) begin
            id_reg        <= arb_idx;
            row_size_reg  <= sel_row_size;
            row_cnt_reg   <= sel_row_cnt;
            frame_off_reg <= sel_frame_off;
            cols_reg      <= sel_cols;
            beats_reg     <= '0;
            err_reg       <= 1'b0;
         end
         if (beat) begin
            beats_reg <= beats_reg + ADDR_W'(1);
         end
         if (((state_reg == ST_LOAD) && reject) || wd_expired) begin
            err_reg <= 1'b1;
         end
         if ((state_reg == ST_DONE) && i_done_ready) begin
            rr_ptr_reg <= id_reg;
         end
      end
   end

   assign o_dp_row_size  = row_size_reg;
   assign o_dp_row_cnt   = row_cnt_reg;
   assign o_dp_frame_off = frame_off_reg;
   assign o_dp_cols      = cols_reg;
   assign o_done_id      = id_reg;
   assign o_done_beats   = beats_reg;
   assign o_done_err     = err_reg;

endmodule

// File: doc/mask_sched.md
# mask_sched

Request scheduler for the column-mask address datapath in the relational cache. It accepts frame-projection jobs from NUM_REQ requesters and arbitrates between them round-robin. It loads the winning job's geometry into the datapath, holds the datapath enable for the whole job, and reports completion with the beat count. It sits between the configuration and prefetch front-ends and the mask/address generator, and it owns that generator exclusively.

## Interface
- NUM_REQ, 2, number of requesters (1..8)
- ADDR_W, 32, address and row-count width
- TIMEOUT_CYCLES, 64, watchdog limit; only used with MASK_SCHED_TIMEOUT_EN
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid  in  NUM_REQ  job request per requester
- o_req_ready  out  NUM_REQ  one-hot accept pulse
- i_req_row_size  in  NUM_REQ×ADDR_W  row stride in bytes
- i_req_row_cnt  in  NUM_REQ×ADDR_W  rows to process
- i_req_frame_off  in  NUM_REQ×ADDR_W  frame base offset
- i_req_cols  in  NUM_REQ×16  enabled column count
- o_dp_en  out  1  datapath enable
- o_dp_row_size, o_dp_row_cnt, o_dp_frame_off  out  ADDR_W  latched job geometry
- o_dp_cols  out  16  latched enabled-column count
- i_dp_active  in  1  datapath output-enable
- i_mem_ready  in  1  downstream ready
- o_dp_ready  out  1  ready forwarded to datapath
- o_done_valid  out  1  completion valid
- i_done_ready  in  1  completion accept
- o_done_id  out  3  requester index of the completed job
- o_done_beats  out  ADDR_W  beats issued (i_dp_active & o_dp_ready)
- o_done_err  out  1  job rejected or timed out
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE: if any i_req_valid is set, pick a winner round-robin, starting at rr_ptr+1 mod NUM_REQ. Pulse its o_req_ready for one cycle and latch its fields into o_dp_* and the id. Then go to LOAD.
- Rejection: if the latched row_cnt==0 or cols==0 or cols>11, skip the datapath. Go to DONE with err=1 and beats=0.
- LOAD: one cycle with o_dp_en=0, so the datapath sees a fresh rising enable. Go to START.
- START: o_dp_en=1. Wait for i_dp_active=1, then go to RUN.
- RUN: o_dp_en=1. Increment the beat counter on each i_dp_active & o_dp_ready. When i_dp_active falls, drop o_dp_en and go to DONE.
- DONE: hold o_done_valid until i_done_ready. Then go to IDLE and set rr_ptr to the served id.
- o_dp_ready = i_mem_ready in START and RUN, and 0 otherwise.
- Requests arriving mid-job wait. Requesters keep i_req_valid and their fields stable until accepted.
- The beat counter wraps modulo 2^ADDR_W.

## Timing
- Reset values: o_req_ready=0, o_dp_en=0, all o_dp_* = 0, o_done_valid=0, o_done_id=0, o_done_beats=0, o_done_err=0, o_busy=0, rr_ptr=NUM_REQ-1.
- Accept-to-o_dp_en latency: 2 cycles (IDLE→LOAD→START).
- o_dp_* are stable from LOAD through DONE.
- A new accept can happen at the earliest 1 cycle after the done handshake.
- If i_done_ready is high on the first DONE cycle, the handshake completes in that cycle.
- Simultaneous requests: the round-robin order decides; the lowest index wins after reset.
- Reset mid-job returns to IDLE on the next edge. o_dp_en drops at the same time and no completion is reported.

## Configuration
- MASK_SCHED_TIMEOUT_EN defined: a watchdog counts cycles in START and counts cycles in RUN where i_mem_ready=1 but no beat occurs. Reaching TIMEOUT_CYCLES forces o_dp_en=0 and DONE with err=1.
- Undefined: no watchdog logic; START waits indefinitely.

## Structure
- Shared package mask_sched_pkg holds the state enum, MAX_COLUMNS=11, and the id width constant.
- One sub-module, rr_arbiter: parameterised NUM_REQ, request vector plus pointer in, one-hot grant and encoded index out, purely combinational.

## Test plan
- Single job from req0 (row_cnt=4, cols=3), model datapath active for 12 cycles, i_mem_ready=1 → o_dp_en rises 2 cycles after accept; done with id=0, beats=12, err=0.
- req0 and req1 both held valid for 4 jobs → grants alternate 0,1,0,1; after reset the first grant is 0.
- Job with cols=0 → no o_dp_en pulse; done with err=1, beats=0 within 2 cycles of accept.
- i_mem_ready toggled 50% during a 12-beat job → o_dp_ready mirrors it; beats=12; done delayed accordingly.
- i_done_ready held low 5 cycles → o_done_valid and the done fields stay stable; no new accept until the handshake.
- Reset asserted mid-RUN → the next cycle has o_dp_en=0, o_busy=0, and no done. With MASK_SCHED_TIMEOUT_EN and i_dp_active stuck at 0 → err=1 after 64 cycles in START.
